truth_table_sweeper: RTL
========================

Name: truth_table_sweeper

Overview:
Synthesisable, self-running exhaustive checker for an N-input single-output Boolean function block.
- Drives every input vector 0..2^N_IN-1 to the device under check and waits a programmable settle time.
- Compares the returned output against an expected truth table held as a parameter, and reports errors.
- Sits beside the combinational Boolean function modules; it replaces the ad-hoc for-loop display benches with a pass/fail result usable in hardware.

Parameters:
- N_IN, 4, number of function inputs (1..8); vec_out bit N_IN-1 is input A (MSB).
- EXP_TT, 16'hA5A5, expected truth table, width 2^N_IN; bit i = expected F for vector i. Default encodes F = (B&D)|(~B&~D).
- SETTLE, 1, cycles vec_out is held before dut_f is sampled (>=1).

Ports:
- clk  in  1  sole clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  single-cycle pulse; begins a sweep when in IDLE or DONE.
- stop_on_fail  in  1  mode; sampled on the accepted start; 1 = halt at first mismatch.
- vec_out  out  N_IN  input vector driven to the function under check.
- dut_f  in  1  function output returned from the function under check.
- busy  out  1  high while a sweep is running.
- done  out  1  high from sweep end until the next accepted start or rst.
- pass  out  1  valid with done; 1 = full sweep completed and err_cnt==0.
- err_cnt  out  N_IN+1  mismatch count (cannot overflow; max 2^N_IN).
- first_fail  out  N_IN  vector of the first mismatch.
- first_fail_vld  out  1  first_fail is valid.

Behaviour:
- Clocking and reset:
  - One clock, clk.
  - Reset is synchronous and active-high on rst, and overrides everything including mid-sweep.
  - On the edge with rst=1, the FSM goes to IDLE and every output clears to 0 (vec_out, busy, done, pass, err_cnt, first_fail, first_fail_vld).
- FSM states: IDLE, WAIT, CHECK, DONE.
- IDLE:
  - On start=1: vec_out<=0, err_cnt<=0, first_fail_vld<=0, first_fail<=0, settle count<=0.
  - Latch stop_on_fail, busy<=1, go to WAIT.
- WAIT:
  - Settle counter increments each cycle.
  - When count==SETTLE-1, go to CHECK.
  - vec_out is stable throughout.
- CHECK (one cycle): mismatch = dut_f != EXP_TT[vec_out].
  - On mismatch: err_cnt<=err_cnt+1. If first_fail_vld==0, set first_fail<=vec_out and first_fail_vld<=1.
  - If vec_out==2^N_IN-1, or (mismatch and latched stop_on_fail): go to DONE, busy<=0, done<=1, pass<=(no errors including this cycle) and (full sweep).
  - Otherwise vec_out<=vec_out+1, settle counter<=0, go to WAIT.
- DONE:
  - Results and vec_out hold.
  - start=1 behaves exactly as start in IDLE (done<=0, pass<=0, counters cleared).
- start during WAIT or CHECK is ignored; the sweep is not restarted.
- Early-halt sweep: pass=0 always.
- Latency: each vector costs SETTLE+1 cycles. done asserts on the edge that ends cycle 2^N_IN*(SETTLE+1) counted from the start edge; default 16*2 = 32 cycles.
- vec_out never wraps past 2^N_IN-1; no increment occurs at the last vector.
- SETTLE<1 or 2^N_IN width mismatch on EXP_TT is a compile-time error (elaboration check).

Decomposition:
- Shared package tt_sweep_pkg holds:
  - the state enum (IDLE, WAIT, CHECK, DONE);
  - localparam N_VEC = 2**N_IN helper function;
  - the default truth-table constant TT_B_XNOR_D = 16'hA5A5.
- One sub-module is natural: settle_timer (clk, rst, clear, expired; parameter SETTLE) generates the WAIT-to-CHECK strobe.
- Everything else stays in the top FSM.

Test Plan:
- Reference model F=(B&D)|(~B&~D), defaults, start pulse, stop_on_fail=0 -> busy for 32 cycles, then done=1, pass=1, err_cnt=0, first_fail_vld=0, vec_out=4'hF.
- dut_f tied 0, stop_on_fail=0 -> done at cycle 32, err_cnt=8, first_fail=0, first_fail_vld=1, pass=0.
- Model inverted only for vector 5, stop_on_fail=1 -> done at cycle 12, vec_out=5, first_fail=5, err_cnt=1, pass=0. Repeat with stop_on_fail=0 -> done at cycle 32, err_cnt=1.
- rst asserted at cycle 10 of a sweep -> next edge: all outputs 0, IDLE. A subsequent start runs a clean 32-cycle sweep.
- start pulsed at cycles 3 and 20 of a sweep -> ignored, done still at cycle 32. start pulsed in DONE -> done drops next edge and a fresh sweep runs.
- N_IN=3, SETTLE=3, EXP_TT=8'h96 (3-input XOR) with an XOR model -> done at cycle 32 (8*4), pass=1. vec_out holds each value for exactly 4 cycles.

Source files
------------

// File: rtl/tt_sweep_pkg.sv
// Shared definitions for the truth-table sweeper.
//   state_t     : sweeper FSM states
//   TT_B_XNOR_D : default expected truth table, F = (B&D)|(~B&~D) for 4 inputs
//   n_vec()     : number of input vectors for an n-input function (2**n)
package tt_sweep_pkg;

   typedef enum logic [1:0] {
      StIdle,
      StWait,
      StCheck,
      StDone
   } state_t;

   localparam logic [15:0] TT_B_XNOR_D = 16'hA5A5;

   function automatic int unsigned n_vec(input int unsigned n_in);
      return 32'd1 << n_in;
   endfunction

endpackage

// File: rtl/truth_table_sweeper_if.sv
// Signal bundle between the sweeper and its environment.
//   start, stop_on_fail : sweep control into the sweeper
//   vec_out, dut_f      : vector to the function under check and its returned output
//   busy, done, pass    : sweep status
//   err_cnt, first_fail, first_fail_vld : sweep results
// master = sweeper side, slave = environment side.
interface truth_table_sweeper_if #(
   parameter int unsigned N_IN = 4
) ();

   logic            start;
   logic            stop_on_fail;
   logic [N_IN-1:0] vec_out;
   logic            dut_f;
   logic            busy;
   logic            done;
   logic            pass;
   logic [N_IN:0]   err_cnt;
   logic [N_IN-1:0] first_fail;
   logic            first_fail_vld;

   modport master (
      input  start, stop_on_fail, dut_f,
      output vec_out, busy, done, pass, err_cnt, first_fail, first_fail_vld
   );

   modport slave (
      output start, stop_on_fail, dut_f,
      input  vec_out, busy, done, pass, err_cnt, first_fail, first_fail_vld
   );

endinterface

// File: rtl/settle_timer.sv
// Settle-time counter for the sweeper.
//   clk, rst : clock and synchronous active-high reset
//   clear    : hold the count at zero (asserted whenever the sweeper is not waiting)
//   expired  : count has reached SETTLE-1; the vector has been stable for SETTLE cycles
module settle_timer #(
   parameter int unsigned SETTLE = 1
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   output logic expired
);

   localparam int unsigned CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [CW-1:0] LAST = CW'(SETTLE - 1);

   logic [CW-1:0] cnt_q;

   // Saturates at LAST so the count can never wrap if clear is late.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         cnt_q <= '0;
      end else if (!expired) begin
         cnt_q <= cnt_q + 1'b1;
      end
   end

   assign expired = (cnt_q == LAST);

endmodule

// File: rtl/truth_table_sweeper.sv
// Exhaustive checker for an N_IN-input, single-output Boolean function.
// Drives every vector 0..2**N_IN-1 on vec_out, waits SETTLE cycles, then compares dut_f
// against bit vec_out of EXP_TT. Each vector costs SETTLE+1 cycles.
//   clk, rst : clock and synchronous active-high reset (overrides a running sweep)
//   bus      : master side of truth_table_sweeper_if
//              start (pulse, accepted in idle/done), stop_on_fail (latched on start),
//              vec_out, dut_f, busy, done, pass, err_cnt, first_fail, first_fail_vld
module truth_table_sweeper
   import tt_sweep_pkg::*;
#(
   parameter int unsigned N_IN   = 4,
   parameter              EXP_TT = TT_B_XNOR_D,
   parameter int unsigned SETTLE = 1
) (
   input logic                   clk,
   input logic                   rst,
   truth_table_sweeper_if.master bus
);

   localparam int unsigned N_VEC = n_vec(N_IN);
   localparam logic [N_IN-1:0] LAST_VEC = {N_IN{1'b1}};

   if (N_IN < 1 || N_IN > 8) begin : g_bad_n_in
      $error("truth_table_sweeper: N_IN must be in 1..8");
   end
   if ($bits(EXP_TT) != N_VEC) begin : g_bad_tt
      $error("truth_table_sweeper: EXP_TT width must be 2**N_IN");
   end
   if (SETTLE < 1) begin : g_bad_settle
      $error("truth_table_sweeper: SETTLE must be at least 1");
   end

   state_t          state_q, state_d;
   logic [N_IN-1:0] vec_q, vec_d;
   logic [N_IN:0]   err_q, err_d;
   logic [N_IN-1:0] ff_q, ff_d;
   logic            ffv_q, ffv_d;
   logic            busy_q, busy_d;
   logic            done_q, done_d;
   logic            pass_q, pass_d;
   logic            sof_q, sof_d;
   logic            settle_done;
   logic            mismatch;

   // Counter only runs in WAIT, so it restarts from zero for every vector.
   settle_timer #(
      .SETTLE (SETTLE)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .clear   (state_q != StWait),
      .expired (settle_done)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= StIdle;
         vec_q   <= '0;
         err_q   <= '0;
         ff_q    <= '0;
         ffv_q   <= 1'b0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         pass_q  <= 1'b0;
         sof_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         vec_q   <= vec_d;
         err_q   <= err_d;
         ff_q    <= ff_d;
         ffv_q   <= ffv_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         pass_q  <= pass_d;
         sof_q   <= sof_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      vec_d    = vec_q;
      err_d    = err_q;
      ff_d     = ff_q;
      ffv_d    = ffv_q;
      busy_d   = busy_q;
      done_d   = done_q;
      pass_d   = pass_q;
      sof_d    = sof_q;
      mismatch = (bus.dut_f != EXP_TT[vec_q]);

      unique case (state_q)
         StIdle, StDone: begin
            if (bus.start) begin
               state_d = StWait;
               vec_d   = '0;
               err_d   = '0;
               ff_d    = '0;
               ffv_d   = 1'b0;
               busy_d  = 1'b1;
               done_d  = 1'b0;
               pass_d  = 1'b0;
               sof_d   = bus.stop_on_fail;
            end
         end
         StWait: begin
            if (settle_done) begin
               state_d = StCheck;
            end
         end
         StCheck: begin
            if (mismatch) begin
               err_d = err_q + 1'b1;
               if (!ffv_q) begin
                  ff_d  = vec_q;
                  ffv_d = 1'b1;
               end
            end
            if (vec_q == LAST_VEC || (mismatch && sof_q)) begin
               state_d = StDone;
               busy_d  = 1'b0;
               done_d  = 1'b1;
               // An early halt never reaches LAST_VEC without a mismatch, so pass stays 0.
               pass_d  = (vec_q == LAST_VEC) && !mismatch && (err_q == '0);
            end else begin
               vec_d   = vec_q + 1'b1;
               state_d = StWait;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   assign bus.vec_out        = vec_q;
   assign bus.busy           = busy_q;
   assign bus.done           = done_q;
   assign bus.pass           = pass_q;
   assign bus.err_cnt        = err_q;
   assign bus.first_fail     = ff_q;
   assign bus.first_fail_vld = ffv_q;

endmodule
